subleq_ctrl: RTL and testbench

Run/debug sequencer for the single-cycle-memory subleq core. Owns the 4-phase instruction sequence (FETCH, READ_A, READ_B, EXEC), the instruction pointer and the shared memory address/write-enable. Arbitrates the single-port memory between the core and a host loader/debug port, which may access memory only while the core is halted. Provides run, stop, single-step, breakpoint and self-loop halt detection.

---
 rtl/subleq_ctrl.sv | 166 ++++++++++++++++
 tb/tb_subleq_ctrl.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/subleq_ctrl.sv
// subleq_ctrl: run/debug sequencer for the subleq core.
// Sequences FETCH/READ_A/READ_B/EXEC and arbitrates memory with the host port.
module subleq_ctrl #(
    parameter int ADDR_W = 13,
    parameter int CNT_W  = 32
) (
    input  logic              iClock,
    input  logic              iReset,
    input  logic              iRun,
    input  logic              iStep,
    input  logic              iHaltReq,
    input  logic              iBreakEn,
    input  logic [ADDR_W-1:0] iBreakAddr,
    input  logic [ADDR_W-1:0] iInstrA,
    input  logic [ADDR_W-1:0] iInstrB,
    input  logic [ADDR_W-1:0] iJump,
    input  logic              iLeq,
    input  logic              iHostReq,
    input  logic              iHostWe,
    input  logic [ADDR_W-1:0] iHostAddr,
    output logic [ADDR_W-1:0] oMemAddr,
    output logic              oMemWe,
    output logic              oMemSel,
    output logic              oLoadInstr,
    output logic              oLoadA,
    output logic              oLoadB,
    output logic [ADDR_W-1:0] oIP,
    output logic              oHostAck,
    output logic              oHalted,
    output logic [2:0]        oHaltCause,
    output logic [CNT_W-1:0]  oInstrCount
);

    typedef enum logic [2:0] {
        S_HALTED,
        S_FETCH,
        S_READ_A,
        S_READ_B,
        S_EXEC,
        S_HOST,
        S_HOST_ACK
    } state_t;

    state_t             state, state_nx;
    logic [ADDR_W-1:0]  ip, ip_nx, new_ip;
    logic [2:0]         cause, cause_nx;
    logic [CNT_W-1:0]   cnt, cnt_nx;
    logic               pend, pend_nx, pend_req;
    logic               step, step_nx;
    logic               we_raw;

    always_ff @(posedge iClock) begin
        if (iReset) begin
            state <= S_HALTED;
            ip    <= '0;
            cause <= 3'd0;
            cnt   <= '0;
            pend  <= 1'b0;
            step  <= 1'b0;
        end else begin
            state <= state_nx;
            ip    <= ip_nx;
            cause <= cause_nx;
            cnt   <= cnt_nx;
            pend  <= pend_nx;
            step  <= step_nx;
        end
    end

    always_comb begin
        state_nx   = state;
        ip_nx      = ip;
        cause_nx   = cause;
        cnt_nx     = cnt;
        pend_nx    = pend;
        step_nx    = step;
        new_ip     = iLeq ? ip + iJump : ip + ADDR_W'(1);
        pend_req   = pend | iHaltReq;
        oMemAddr   = ip;
        we_raw     = 1'b0;
        oMemSel    = 1'b0;
        oLoadInstr = 1'b0;
        oLoadA     = 1'b0;
        oLoadB     = 1'b0;
        oHostAck   = 1'b0;
        oHalted    = 1'b0;

        unique case (state)
            S_HALTED: begin
                oHalted = 1'b1;
                if (iHostReq) begin
                    state_nx = S_HOST;
                end else if (iRun) begin
                    state_nx = S_FETCH;
                    step_nx  = 1'b0;
                end else if (iStep) begin
                    state_nx = S_FETCH;
                    step_nx  = 1'b1;
                end
            end
            S_FETCH: begin
                oLoadInstr = 1'b1;
                pend_nx    = pend_req;
                state_nx   = S_READ_A;
            end
            S_READ_A: begin
                oMemAddr = iInstrA;
                oLoadA   = 1'b1;
                pend_nx  = pend_req;
                state_nx = S_READ_B;
            end
            S_READ_B: begin
                oMemAddr = iInstrB;
                oLoadB   = 1'b1;
                pend_nx  = pend_req;
                state_nx = S_EXEC;
            end
            S_EXEC: begin
                oMemAddr = iInstrB;
                we_raw   = 1'b1;
                ip_nx    = new_ip;
                pend_nx  = pend_req;
                state_nx = S_HALTED;
                if (cnt != '1)
                    cnt_nx = cnt + CNT_W'(1);
                // first matching halt reason wins
                if (iLeq && (iJump == '0))
                    cause_nx = 3'd1;
                else if (pend_req)
                    cause_nx = 3'd2;
                else if (iBreakEn && (new_ip == iBreakAddr))
                    cause_nx = 3'd3;
                else if (step)
                    cause_nx = 3'd4;
                else
                    state_nx = S_FETCH;
                if (state_nx == S_HALTED) begin
                    pend_nx = 1'b0;
                    step_nx = 1'b0;
                end
            end
            S_HOST: begin
                oHalted  = 1'b1;
                oMemAddr = iHostAddr;
                oMemSel  = 1'b1;
                we_raw   = iHostWe;
                state_nx = S_HOST_ACK;
            end
            S_HOST_ACK: begin
                oHalted  = 1'b1;
                oMemAddr = iHostAddr;
                oMemSel  = 1'b1;
                oHostAck = 1'b1;
                state_nx = S_HALTED;
            end
            default: state_nx = S_HALTED;
        endcase
    end

    // reset suppresses any write already set up in this cycle
    assign oMemWe      = we_raw & ~iReset;
    assign oIP         = ip;
    assign oHaltCause  = cause;
    assign oInstrCount = cnt;

endmodule

// File: tb/tb_subleq_ctrl.sv
// tb_subleq_ctrl: directed bench with a halt/read-data scoreboard.
// Program: A=IP+100, B=IP+200, IP 3 branches by jump3, others fall through.
module tb_subleq_ctrl;

    localparam int AW = 13;
    localparam int CW = 32;

    logic          iClock = 1'b0;
    logic          iReset, iRun, iStep, iHaltReq, iBreakEn;
    logic [AW-1:0] iBreakAddr, iInstrA, iInstrB, iJump, iHostAddr;
    logic          iLeq, iHostReq, iHostWe;
    logic [AW-1:0] oMemAddr, oIP;
    logic          oMemWe, oMemSel, oLoadInstr, oLoadA, oLoadB;
    logic          oHostAck, oHalted;
    logic [2:0]    oHaltCause;
    logic [CW-1:0] oInstrCount;

    logic [AW-1:0] jump3;
    logic [15:0]   mem [0:8191];
    logic [15:0]   q, host_wd, core_wd;
    int            we_count = 0;
    int            wc;
    int            checks = 0;
    int            failures = 0;

    typedef struct {
        logic [AW-1:0] ip;
        logic [2:0]    cause;
        logic [CW-1:0] cnt;
    } exp_t;
    exp_t        sbq[$];
    logic [15:0] rdq[$];

    always #5 iClock = ~iClock;

    subleq_ctrl #(.ADDR_W(AW), .CNT_W(CW)) dut (
        .iClock(iClock), .iReset(iReset), .iRun(iRun), .iStep(iStep),
        .iHaltReq(iHaltReq), .iBreakEn(iBreakEn), .iBreakAddr(iBreakAddr),
        .iInstrA(iInstrA), .iInstrB(iInstrB), .iJump(iJump), .iLeq(iLeq),
        .iHostReq(iHostReq), .iHostWe(iHostWe), .iHostAddr(iHostAddr),
        .oMemAddr(oMemAddr), .oMemWe(oMemWe), .oMemSel(oMemSel),
        .oLoadInstr(oLoadInstr), .oLoadA(oLoadA), .oLoadB(oLoadB),
        .oIP(oIP), .oHostAck(oHostAck), .oHalted(oHalted),
        .oHaltCause(oHaltCause), .oInstrCount(oInstrCount)
    );

    always_comb begin
        iInstrA = oIP + AW'(100);
        iInstrB = oIP + AW'(200);
        iLeq    = (oIP == AW'(3));
        iJump   = (oIP == AW'(3)) ? jump3 : AW'(7);
    end

    always @(posedge iClock) begin
        q <= mem[oMemAddr];
        if (oMemWe === 1'b1)
            mem[oMemAddr] <= oMemSel ? host_wd : core_wd;
    end

    always @(negedge iClock)
        if (oMemWe === 1'b1) we_count++;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge iClock);
        #1;
    endtask

    task automatic wait_halt(input string tag);
        int   n;
        exp_t e;
        n = 0;
        while (oHalted !== 1'b1 && n < 200) begin
            tick();
            n++;
        end
        chk({tag, "_halted"}, {31'b0, oHalted}, 32'd1);
        if (sbq.size() > 0) begin
            e = sbq.pop_front();
            chk({tag, "_ip"}, {19'b0, oIP}, {19'b0, e.ip});
            chk({tag, "_cause"}, {29'b0, oHaltCause}, {29'b0, e.cause});
            chk({tag, "_cnt"}, oInstrCount, e.cnt);
        end
    endtask

    task automatic run_pulse();
        iRun = 1'b1;
        tick();
        iRun = 1'b0;
    endtask

    task automatic step_pulse();
        iStep = 1'b1;
        tick();
        iStep = 1'b0;
    endtask

    initial begin
        iReset = 1'b1; iRun = 1'b0; iStep = 1'b0; iHaltReq = 1'b0;
        iBreakEn = 1'b0; iBreakAddr = '0; iHostReq = 1'b0;
        iHostWe = 1'b0; iHostAddr = '0; jump3 = '0;
        host_wd = 16'h0; core_wd = 16'h5555;
        tick();
        tick();
        iReset = 1'b0;
        repeat (10) tick();
        chk("rst_halted", {31'b0, oHalted}, 32'd1);
        chk("rst_cause", {29'b0, oHaltCause}, 32'd0);
        chk("rst_ip", {19'b0, oIP}, 32'd0);
        chk("rst_cnt", oInstrCount, 32'd0);
        chk("rst_nowe", we_count, 32'd0);
        chk("rst_addr", {19'b0, oMemAddr}, 32'd0);

        iHostReq = 1'b1; iHostWe = 1'b1; iHostAddr = AW'(5);
        host_wd = 16'hABCD;
        tick();
        chk("hw_we", {31'b0, oMemWe}, 32'd1);
        chk("hw_sel", {31'b0, oMemSel}, 32'd1);
        chk("hw_addr", {19'b0, oMemAddr}, 32'd5);
        chk("hw_noack", {31'b0, oHostAck}, 32'd0);
        tick();
        chk("hw_ack", {31'b0, oHostAck}, 32'd1);
        chk("hw_ackwe", {31'b0, oMemWe}, 32'd0);
        iHostReq = 1'b0;
        tick();
        chk("hw_idle", {31'b0, oHostAck}, 32'd0);

        rdq.push_back(16'hABCD);
        iHostReq = 1'b1; iHostWe = 1'b0; host_wd = 16'h1111;
        tick();
        chk("hr_we", {31'b0, oMemWe}, 32'd0);
        tick();
        chk("hr_ack", {31'b0, oHostAck}, 32'd1);
        chk("hr_q", {16'b0, q}, {16'b0, rdq.pop_front()});
        iHostReq = 1'b0;
        tick();

        sbq.push_back('{AW'(1), 3'd4, CW'(1)});
        step_pulse();
        chk("st_f_li", {31'b0, oLoadInstr}, 32'd1);
        chk("st_f_addr", {19'b0, oMemAddr}, 32'd0);
        chk("st_f_we", {31'b0, oMemWe}, 32'd0);
        tick();
        chk("st_a_la", {31'b0, oLoadA}, 32'd1);
        chk("st_a_li", {31'b0, oLoadInstr}, 32'd0);
        chk("st_a_addr", {19'b0, oMemAddr}, 32'd100);
        tick();
        chk("st_b_lb", {31'b0, oLoadB}, 32'd1);
        chk("st_b_addr", {19'b0, oMemAddr}, 32'd200);
        chk("st_b_we", {31'b0, oMemWe}, 32'd0);
        tick();
        chk("st_e_we", {31'b0, oMemWe}, 32'd1);
        chk("st_e_sel", {31'b0, oMemSel}, 32'd0);
        chk("st_e_addr", {19'b0, oMemAddr}, 32'd200);
        tick();
        wait_halt("step");

        sbq.push_back('{AW'(3), 3'd1, CW'(4)});
        run_pulse();
        wait_halt("selfloop");
        sbq.push_back('{AW'(3), 3'd1, CW'(5)});
        run_pulse();
        wait_halt("selfloop2");

        iHostReq = 1'b1; iHostWe = 1'b0; iHostAddr = AW'(5); iRun = 1'b1;
        tick();
        iRun = 1'b0;
        chk("coll_host", {31'b0, oMemSel}, 32'd1);
        tick();
        chk("coll_ack", {31'b0, oHostAck}, 32'd1);
        iHostReq = 1'b0;
        tick();
        tick();
        chk("coll_halted", {31'b0, oHalted}, 32'd1);
        chk("coll_noli", {31'b0, oLoadInstr}, 32'd0);
        chk("coll_ip", {19'b0, oIP}, 32'd3);
        chk("coll_cnt", oInstrCount, 32'd5);

        run_pulse();
        tick();
        tick();
        chk("rb_lb", {31'b0, oLoadB}, 32'd1);
        wc = we_count;
        iReset = 1'b1;
        tick();
        iReset = 1'b0;
        chk("rb_halted", {31'b0, oHalted}, 32'd1);
        chk("rb_ip", {19'b0, oIP}, 32'd0);
        chk("rb_cnt", oInstrCount, 32'd0);
        chk("rb_cause", {29'b0, oHaltCause}, 32'd0);
        chk("rb_nowe", we_count, wc);

        run_pulse();
        tick();
        tick();
        tick();
        chk("re_we", {31'b0, oMemWe}, 32'd1);
        wc = we_count;
        iReset = 1'b1;
        #1;
        chk("re_gate", {31'b0, oMemWe}, 32'd0);
        tick();
        iReset = 1'b0;
        chk("re_halted", {31'b0, oHalted}, 32'd1);
        chk("re_ip", {19'b0, oIP}, 32'd0);
        chk("re_nowe", we_count, wc);

        iBreakEn = 1'b1; iBreakAddr = AW'(2);
        sbq.push_back('{AW'(2), 3'd3, CW'(2)});
        run_pulse();
        wait_halt("bp");
        sbq.push_back('{AW'(3), 3'd2, CW'(3)});
        wc = we_count;
        run_pulse();
        tick();
        chk("hq_ra", {31'b0, oLoadA}, 32'd1);
        iHaltReq = 1'b1;
        tick();
        iHaltReq = 1'b0;
        wait_halt("haltreq");
        chk("hq_wrote", we_count, wc + 1);
        iBreakEn = 1'b0;

        jump3 = AW'(8188);
        sbq.push_back('{AW'(8191), 3'd4, CW'(4)});
        step_pulse();
        wait_halt("tomax");
        sbq.push_back('{AW'(0), 3'd4, CW'(5)});
        step_pulse();
        wait_halt("wrap");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
